// File: rtl/alu_exec_unit_pkg.sv
// alu_exec_unit_pkg: shared widths and ALU opcode encodings for the ALU execute lane.
// The backtick constants stand in for the core-wide constants header. Each one is only
// defined here when nothing earlier in the compile has already defined it.
`ifndef RV32_DATA_WIDTH
`define RV32_DATA_WIDTH 32
`endif
`ifndef ROB_TAG_WIDTH
`define ROB_TAG_WIDTH 6
`endif
`ifndef ALU_OP_SEL
`define ALU_OP_SEL 4
`endif
`ifndef ALU_OP_ADD
`define ALU_OP_ADD  4'd0
`define ALU_OP_SUB  4'd1
`define ALU_OP_AND  4'd2
`define ALU_OP_OR   4'd3
`define ALU_OP_XOR  4'd4
`define ALU_OP_SLL  4'd5
`define ALU_OP_SRL  4'd6
`define ALU_OP_SRA  4'd7
`define ALU_OP_SLT  4'd8
`define ALU_OP_SLTU 4'd9
`define ALU_OP_SEQ  4'd10
`define ALU_OP_SNE  4'd11
`define ALU_OP_SGE  4'd12
`define ALU_OP_SGEU 4'd13
`endif

package alu_exec_unit_pkg;
   localparam int OP_W = `ALU_OP_SEL;

   // Compare ops produce 0/1. Branches use bit 0 of that result as the taken flag.
   typedef enum logic [OP_W-1:0] {
      OP_ADD  = `ALU_OP_ADD,
      OP_SUB  = `ALU_OP_SUB,
      OP_AND  = `ALU_OP_AND,
      OP_OR   = `ALU_OP_OR,
      OP_XOR  = `ALU_OP_XOR,
      OP_SLL  = `ALU_OP_SLL,
      OP_SRL  = `ALU_OP_SRL,
      OP_SRA  = `ALU_OP_SRA,
      OP_SLT  = `ALU_OP_SLT,
      OP_SLTU = `ALU_OP_SLTU,
      OP_SEQ  = `ALU_OP_SEQ,
      OP_SNE  = `ALU_OP_SNE,
      OP_SGE  = `ALU_OP_SGE,
      OP_SGEU = `ALU_OP_SGEU
   } alu_op_e;
endpackage

// File: rtl/alu_exec_unit_alu.sv
// alu: combinational integer ALU shared by the execute lanes.
// Compare ops return 0 or 1 in bit 0. Unused opcodes return 0.
module alu
   import alu_exec_unit_pkg::*;
#(
   parameter int DATA_W = `RV32_DATA_WIDTH
) (
   input  logic [OP_W-1:0]   i_op,
   input  logic [DATA_W-1:0] i_a,
   input  logic [DATA_W-1:0] i_b,
   output logic [DATA_W-1:0] o_res
);
   localparam int SH_W = $clog2(DATA_W);

   logic [SH_W-1:0] shamt;
   logic            lt_s;
   logic            lt_u;
   logic            eq;

   // operation select
   always_comb begin
      shamt = i_b[SH_W-1:0];
      lt_s  = $signed(i_a) < $signed(i_b);
      lt_u  = i_a < i_b;
      eq    = i_a == i_b;
      o_res = '0;
      case (alu_op_e'(i_op))
         OP_ADD:  o_res = i_a + i_b;
         OP_SUB:  o_res = i_a - i_b;
         OP_AND:  o_res = i_a & i_b;
         OP_OR:   o_res = i_a | i_b;
         OP_XOR:  o_res = i_a ^ i_b;
         OP_SLL:  o_res = i_a << shamt;
         OP_SRL:  o_res = i_a >> shamt;
         OP_SRA:  o_res = $signed(i_a) >>> shamt;
         OP_SLT:  o_res = {{(DATA_W-1){1'b0}}, lt_s};
         OP_SLTU: o_res = {{(DATA_W-1){1'b0}}, lt_u};
         OP_SEQ:  o_res = {{(DATA_W-1){1'b0}}, eq};
         OP_SNE:  o_res = {{(DATA_W-1){1'b0}}, !eq};
         OP_SGE:  o_res = {{(DATA_W-1){1'b0}}, !lt_s};
         OP_SGEU: o_res = {{(DATA_W-1){1'b0}}, !lt_u};
         default: o_res = '0;
      endcase
   end
endmodule

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: two-stage ALU execute lane (EX, WB) with valid/ready issue, a CDB port
// with backpressure, flush, and conditional branch resolution.
// Optional macro ALU_EXEC_PERF_EN enables the completed-op and CDB-stall counters.
// Without that macro both counter ports are tied to 0.
module alu_exec_unit
   import alu_exec_unit_pkg::*;
#(
   parameter int ROB_TAG_W = `ROB_TAG_WIDTH,
   parameter int DATA_W    = `RV32_DATA_WIDTH
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_flush,
   input  logic                 i_issue_vld,
   output logic                 o_issue_rdy,
   input  logic [OP_W-1:0]      i_alu_op,
   input  logic [DATA_W-1:0]    i_src1,
   input  logic [DATA_W-1:0]    i_src2,
   input  logic [ROB_TAG_W-1:0] i_rob_tag,
   input  logic                 i_is_branch,
   input  logic [DATA_W-1:0]    i_pc,
   input  logic [DATA_W-1:0]    i_br_offset,
   input  logic                 i_pred_taken,
   output logic                 o_cdb_vld,
   input  logic                 i_cdb_rdy,
   output logic [ROB_TAG_W-1:0] o_cdb_tag,
   output logic [DATA_W-1:0]    o_cdb_data,
   output logic                 o_cdb_is_branch,
   output logic                 o_cdb_br_taken,
   output logic [DATA_W-1:0]    o_cdb_br_target,
   output logic                 o_cdb_mispred,
   output logic [31:0]          o_exec_cnt,
   output logic [31:0]          o_stall_cnt
);
   logic                 wb_adv, ex_adv, issue_fire, wb_load;

   logic                 ex_vld_q, ex_vld_d;
   logic [OP_W-1:0]      ex_op_q, ex_op_d;
   logic [DATA_W-1:0]    ex_src1_q, ex_src1_d, ex_src2_q, ex_src2_d;
   logic [ROB_TAG_W-1:0] ex_tag_q, ex_tag_d;
   logic                 ex_is_br_q, ex_is_br_d, ex_pred_q, ex_pred_d;
   logic [DATA_W-1:0]    ex_pc_q, ex_pc_d, ex_off_q, ex_off_d;

   logic                 wb_vld_q, wb_vld_d;
   logic [ROB_TAG_W-1:0] wb_tag_q, wb_tag_d;
   logic [DATA_W-1:0]    wb_data_q, wb_data_d, wb_target_q, wb_target_d;
   logic                 wb_is_br_q, wb_is_br_d, wb_taken_q, wb_taken_d, wb_mispred_q, wb_mispred_d;

   logic [DATA_W-1:0]    alu_res;
   logic                 br_taken;

   alu #(.DATA_W(DATA_W)) u_alu (
      .i_op  (ex_op_q),
      .i_a   (ex_src1_q),
      .i_b   (ex_src2_q),
      .o_res (alu_res)
   );

   // pipeline handshakes; ready sees i_cdb_rdy and i_flush, never i_issue_vld
   always_comb begin
      wb_adv      = !wb_vld_q || i_cdb_rdy;
      ex_adv      = !ex_vld_q || wb_adv;
      o_issue_rdy = ex_adv && !i_flush;
      issue_fire  = i_issue_vld && o_issue_rdy;
      wb_load     = wb_adv && ex_vld_q && !i_flush;
   end

   // EX stage next state; payload flops load only on an accepted issue
   always_comb begin
      ex_vld_d   = ex_vld_q;
      ex_op_d    = ex_op_q;
      ex_src1_d  = ex_src1_q;
      ex_src2_d  = ex_src2_q;
      ex_tag_d   = ex_tag_q;
      ex_is_br_d = ex_is_br_q;
      ex_pc_d    = ex_pc_q;
      ex_off_d   = ex_off_q;
      ex_pred_d  = ex_pred_q;
      if (i_flush)     ex_vld_d = 1'b0;
      else if (ex_adv) ex_vld_d = i_issue_vld;
      if (issue_fire) begin
         ex_op_d    = i_alu_op;
         ex_src1_d  = i_src1;
         ex_src2_d  = i_src2;
         ex_tag_d   = i_rob_tag;
         ex_is_br_d = i_is_branch;
         ex_pc_d    = i_pc;
         ex_off_d   = i_br_offset;
         ex_pred_d  = i_pred_taken;
      end
   end

   // WB stage next state: branches return PC+4 as data and PC+offset as target
   always_comb begin
      br_taken     = ex_is_br_q && alu_res[0];
      wb_vld_d     = wb_vld_q;
      wb_tag_d     = wb_tag_q;
      wb_data_d    = wb_data_q;
      wb_is_br_d   = wb_is_br_q;
      wb_taken_d   = wb_taken_q;
      wb_target_d  = wb_target_q;
      wb_mispred_d = wb_mispred_q;
      if (i_flush)     wb_vld_d = 1'b0;
      else if (wb_adv) wb_vld_d = ex_vld_q;
      if (wb_load) begin
         wb_tag_d     = ex_tag_q;
         wb_is_br_d   = ex_is_br_q;
         wb_taken_d   = br_taken;
         wb_data_d    = ex_is_br_q ? ex_pc_q + DATA_W'(4) : alu_res;
         wb_target_d  = ex_is_br_q ? ex_pc_q + ex_off_q : '0;
         wb_mispred_d = ex_is_br_q && (br_taken != ex_pred_q);
      end
   end

   // pipeline registers
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         ex_vld_q     <= 1'b0;
         ex_op_q      <= '0;
         ex_src1_q    <= '0;
         ex_src2_q    <= '0;
         ex_tag_q     <= '0;
         ex_is_br_q   <= 1'b0;
         ex_pc_q      <= '0;
         ex_off_q     <= '0;
         ex_pred_q    <= 1'b0;
         wb_vld_q     <= 1'b0;
         wb_tag_q     <= '0;
         wb_data_q    <= '0;
         wb_is_br_q   <= 1'b0;
         wb_taken_q   <= 1'b0;
         wb_target_q  <= '0;
         wb_mispred_q <= 1'b0;
      end else begin
         ex_vld_q     <= ex_vld_d;
         ex_op_q      <= ex_op_d;
         ex_src1_q    <= ex_src1_d;
         ex_src2_q    <= ex_src2_d;
         ex_tag_q     <= ex_tag_d;
         ex_is_br_q   <= ex_is_br_d;
         ex_pc_q      <= ex_pc_d;
         ex_off_q     <= ex_off_d;
         ex_pred_q    <= ex_pred_d;
         wb_vld_q     <= wb_vld_d;
         wb_tag_q     <= wb_tag_d;
         wb_data_q    <= wb_data_d;
         wb_is_br_q   <= wb_is_br_d;
         wb_taken_q   <= wb_taken_d;
         wb_target_q  <= wb_target_d;
         wb_mispred_q <= wb_mispred_d;
      end
   end

   assign o_cdb_vld       = wb_vld_q;
   assign o_cdb_tag       = wb_tag_q;
   assign o_cdb_data      = wb_data_q;
   assign o_cdb_is_branch = wb_is_br_q;
   assign o_cdb_br_taken  = wb_taken_q;
   assign o_cdb_br_target = wb_target_q;
   assign o_cdb_mispred   = wb_mispred_q;

`ifdef ALU_EXEC_PERF_EN
   logic [31:0] exec_cnt_q, exec_cnt_d, stall_cnt_q, stall_cnt_d;

   // performance counters, deliberately not cleared by flush
   always_comb begin
      exec_cnt_d  = exec_cnt_q;
      stall_cnt_d = stall_cnt_q;
      if (wb_vld_q && i_cdb_rdy)  exec_cnt_d  = exec_cnt_q + 32'd1;
      if (wb_vld_q && !i_cdb_rdy) stall_cnt_d = stall_cnt_q + 32'd1;
   end

   // counter registers
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         exec_cnt_q  <= '0;
         stall_cnt_q <= '0;
      end else begin
         exec_cnt_q  <= exec_cnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign o_exec_cnt  = exec_cnt_q;
   assign o_stall_cnt = stall_cnt_q;
`else
   assign o_exec_cnt  = '0;
   assign o_stall_cnt = '0;
`endif
endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: directed scenarios plus a randomized run against a queue-based
// reference model of the ALU execute lane.
module tb_alu_exec_unit;
   import alu_exec_unit_pkg::*;
   localparam int TW = `ROB_TAG_WIDTH;

   logic          clk = 1'b0;
   logic          rst_n, flush, issue_vld, issue_rdy, is_branch, pred_taken;
   logic [OP_W-1:0] alu_op;
   logic [31:0]   src1, src2, pc, br_offset;
   logic [TW-1:0] rob_tag, cdb_tag;
   logic          cdb_vld, cdb_rdy, cdb_is_branch, cdb_br_taken, cdb_mispred;
   logic [31:0]   cdb_data, cdb_br_target, exec_cnt, stall_cnt;

   int checks = 0;
   int errors = 0;
   int exp_exec = 0;
   int exp_stall = 0;

   typedef struct {
      logic [TW-1:0] tag;
      logic [31:0]   data;
      logic          is_br;
      logic          taken;
      logic [31:0]   target;
      logic          mispred;
      int            acc;
   } exp_t;
   exp_t q[$];

   always #5 clk = ~clk;

   alu_exec_unit dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush),
      .i_issue_vld(issue_vld), .o_issue_rdy(issue_rdy),
      .i_alu_op(alu_op), .i_src1(src1), .i_src2(src2), .i_rob_tag(rob_tag),
      .i_is_branch(is_branch), .i_pc(pc), .i_br_offset(br_offset), .i_pred_taken(pred_taken),
      .o_cdb_vld(cdb_vld), .i_cdb_rdy(cdb_rdy), .o_cdb_tag(cdb_tag), .o_cdb_data(cdb_data),
      .o_cdb_is_branch(cdb_is_branch), .o_cdb_br_taken(cdb_br_taken),
      .o_cdb_br_target(cdb_br_target), .o_cdb_mispred(cdb_mispred),
      .o_exec_cnt(exec_cnt), .o_stall_cnt(stall_cnt)
   );

   function automatic logic [31:0] perf_exp(int v);
`ifdef ALU_EXEC_PERF_EN
      return 32'(v);
`else
      return 32'd0;
`endif
   endfunction

   // Reference model: result computed directly from the instruction semantics.
   function automatic exp_t ref_model(logic [3:0] op, logic [31:0] a, logic [31:0] b,
                                      logic [TW-1:0] tag, logic isb, logic [31:0] p,
                                      logic [31:0] off, logic pred, int acc);
      exp_t e;
      logic [31:0] r;
      logic signed [31:0] sa, sb;
      int sh;
      sa = a; sb = b; sh = int'(b[4:0]);
      case (op)
         4'd0:  r = a + b;
         4'd1:  r = a - b;
         4'd2:  r = a & b;
         4'd3:  r = a | b;
         4'd4:  r = a ^ b;
         4'd5:  r = a << sh;
         4'd6:  r = a >> sh;
         4'd7:  r = sa >>> sh;
         4'd8:  r = (sa < sb) ? 32'd1 : 32'd0;
         4'd9:  r = (a < b) ? 32'd1 : 32'd0;
         4'd10: r = (a == b) ? 32'd1 : 32'd0;
         4'd11: r = (a != b) ? 32'd1 : 32'd0;
         4'd12: r = (sa >= sb) ? 32'd1 : 32'd0;
         4'd13: r = (a >= b) ? 32'd1 : 32'd0;
         default: r = 32'd0;
      endcase
      e.tag = tag; e.acc = acc; e.is_br = isb;
      if (isb) begin
         e.taken = r[0]; e.data = p + 32'd4; e.target = p + off; e.mispred = (r[0] != pred);
      end else begin
         e.taken = 1'b0; e.data = r; e.target = 32'd0; e.mispred = 1'b0;
      end
      return e;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_issue(logic [3:0] op, logic [31:0] a, logic [31:0] b, logic [TW-1:0] tag,
                            logic isb, logic [31:0] p, logic [31:0] off, logic pred);
      issue_vld = 1'b1; alu_op = op; src1 = a; src2 = b; rob_tag = tag;
      is_branch = isb; pc = p; br_offset = off; pred_taken = pred;
   endtask

   task automatic set_idle();
      issue_vld = 1'b0;
      flush = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; cdb_rdy = 1'b1;
      set_idle();
      set_issue(4'd0, 0, 0, 0, 0, 0, 0, 0);
      issue_vld = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if ({cdb_vld, cdb_tag, cdb_data, cdb_is_branch, cdb_br_taken, cdb_br_target, cdb_mispred} !== '0) begin
         errors++; $display("FAIL reset_cdb got vld=%b data=%h tag=%h want all 0", cdb_vld, cdb_data, cdb_tag);
      end
      checks++;
      if (exec_cnt !== 32'd0 || stall_cnt !== 32'd0) begin
         errors++; $display("FAIL reset_cnt got %0d/%0d want 0/0", exec_cnt, stall_cnt);
      end
      checks++;
      if (issue_rdy !== 1'b1) begin
         errors++; $display("FAIL reset_rdy got %b want 1", issue_rdy);
      end
      rst_n = 1'b1;
      tick();
      @(negedge clk);
      checks++;
      if (cdb_vld !== 1'b0 || cdb_data !== 32'd0 || issue_rdy !== 1'b1) begin
         errors++; $display("FAIL post_reset got vld=%b data=%h rdy=%b want 0/0/1", cdb_vld, cdb_data, issue_rdy);
      end
   endtask

   task automatic test_add_latency();
      tick();
      cdb_rdy = 1'b1;
      set_issue(4'd0, 32'd5, 32'd7, TW'(3), 0, 0, 0, 0);
      @(negedge clk);
      checks++;
      if (issue_rdy !== 1'b1) begin errors++; $display("FAIL add_rdy got %b want 1", issue_rdy); end
      tick(); set_idle();
      @(negedge clk);
      checks++;
      if (cdb_vld !== 1'b0) begin errors++; $display("FAIL add_early got vld=%b want 0", cdb_vld); end
      tick();
      @(negedge clk);
      checks++;
      if (cdb_vld !== 1'b1 || cdb_data !== 32'd12 || cdb_tag !== TW'(3) || cdb_is_branch !== 1'b0) begin
         errors++; $display("FAIL add_result got vld=%b data=%h tag=%0d want 1/0000000c/3", cdb_vld, cdb_data, cdb_tag);
      end
      exp_exec++;
      tick();
      @(negedge clk);
      checks++;
      if (cdb_vld !== 1'b0) begin errors++; $display("FAIL add_after got vld=%b want 0", cdb_vld); end
   endtask

   task automatic test_back_to_back();
      logic [3:0]  ops [3] = '{4'd1, 4'd7, 4'd9};
      logic [31:0] as  [3] = '{32'd1, 32'h8000_0000, 32'd1};
      logic [31:0] bs  [3] = '{32'd2, 32'd4, 32'd2};
      logic [31:0] exd [3] = '{32'hFFFF_FFFF, 32'hF800_0000, 32'd1};
      cdb_rdy = 1'b1;
      for (int c = 0; c < 6; c++) begin
         tick();
         if (c < 3) set_issue(ops[c], as[c], bs[c], TW'(10 + c), 0, 0, 0, 0);
         else set_idle();
         @(negedge clk);
         if (c < 3) begin
            checks++;
            if (issue_rdy !== 1'b1) begin errors++; $display("FAIL b2b_rdy c=%0d got %b want 1", c, issue_rdy); end
         end
         checks++;
         if (c >= 2 && c < 5) begin
            if (cdb_vld !== 1'b1 || cdb_data !== exd[c-2] || cdb_tag !== TW'(8 + c)) begin
               errors++; $display("FAIL b2b_res c=%0d got vld=%b data=%h tag=%0d want 1/%h/%0d", c, cdb_vld, cdb_data, cdb_tag, exd[c-2], 8 + c);
            end
            exp_exec++;
         end else if (cdb_vld !== 1'b0) begin
            errors++; $display("FAIL b2b_idle c=%0d got vld=%b want 0", c, cdb_vld);
         end
      end
   endtask

   task automatic test_backpressure();
      logic        rdy_e [8] = '{1, 1, 0, 0, 0, 0, 0, 1};
      logic [31:0] da = 32'd123, db = 32'h0F0F_F0F0, dc = 32'h300;
      for (int c = 0; c < 11; c++) begin
         tick();
         cdb_rdy = (c >= 7);
         if (c == 0)      set_issue(4'd0, 32'd100, 32'd23, TW'(20), 0, 0, 0, 0);
         else if (c == 1) set_issue(4'd4, 32'hF0F0_F0F0, 32'hFFFF_0000, TW'(21), 0, 0, 0, 0);
         else if (c <= 7) set_issue(4'd5, 32'd3, 32'd8, TW'(22), 0, 0, 0, 0);
         else set_idle();
         @(negedge clk);
         if (c <= 7) begin
            checks++;
            if (issue_rdy !== rdy_e[c]) begin errors++; $display("FAIL bp_rdy c=%0d got %b want %b", c, issue_rdy, rdy_e[c]); end
         end
         checks++;
         if (c >= 2 && c <= 7) begin
            if (cdb_vld !== 1'b1 || cdb_data !== da || cdb_tag !== TW'(20)) begin
               errors++; $display("FAIL bp_hold c=%0d got vld=%b data=%h tag=%0d want 1/%h/20", c, cdb_vld, cdb_data, cdb_tag, da);
            end
         end else if (c == 8) begin
            if (cdb_vld !== 1'b1 || cdb_data !== db || cdb_tag !== TW'(21)) begin
               errors++; $display("FAIL bp_second got vld=%b data=%h tag=%0d want 1/%h/21", cdb_vld, cdb_data, cdb_tag, db);
            end
         end else if (c == 9) begin
            if (cdb_vld !== 1'b1 || cdb_data !== dc || cdb_tag !== TW'(22)) begin
               errors++; $display("FAIL bp_third got vld=%b data=%h tag=%0d want 1/%h/22", cdb_vld, cdb_data, cdb_tag, dc);
            end
         end else if (cdb_vld !== 1'b0) begin
            errors++; $display("FAIL bp_idle c=%0d got vld=%b want 0", c, cdb_vld);
         end
      end
      exp_stall += 5;
      exp_exec += 3;
      checks++;
      if (stall_cnt !== perf_exp(exp_stall) || exec_cnt !== perf_exp(exp_exec)) begin
         errors++; $display("FAIL bp_counters got exec=%0d stall=%0d want %0d/%0d", exec_cnt, stall_cnt, perf_exp(exp_exec), perf_exp(exp_stall));
      end
   endtask

   task automatic test_branch();
      logic [3:0]  ops [3] = '{4'd8, 4'd13, 4'd8};
      logic [31:0] as  [3] = '{32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFFF};
      logic [31:0] bs  [3] = '{32'd0, 32'hFFFF_FFFF, 32'd0};
      logic        isb [3] = '{1, 1, 0};
      logic [31:0] pcs [3] = '{32'h100, 32'h200, 32'h300};
      logic [31:0] ofs [3] = '{32'h20, 32'hFFFF_FFF0, 32'h40};
      logic [31:0] e_data [3] = '{32'h104, 32'h204, 32'd1};
      logic [31:0] e_tgt  [3] = '{32'h120, 32'h1F0, 32'd0};
      logic [2:0]  e_flag [3] = '{3'b111, 3'b100, 3'b000};
      cdb_rdy = 1'b1;
      for (int c = 0; c < 6; c++) begin
         tick();
         if (c < 3) set_issue(ops[c], as[c], bs[c], TW'(5 + c), isb[c], pcs[c], ofs[c], 1'b0);
         else set_idle();
         @(negedge clk);
         if (c >= 2 && c < 5) begin
            checks++;
            if (cdb_vld !== 1'b1 || cdb_data !== e_data[c-2] || cdb_br_target !== e_tgt[c-2] ||
                {cdb_is_branch, cdb_br_taken, cdb_mispred} !== e_flag[c-2] || cdb_tag !== TW'(3 + c)) begin
               errors++; $display("FAIL branch_%0d got vld=%b data=%h tgt=%h br/tk/mp=%b%b%b want 1/%h/%h/%b", c - 2, cdb_vld, cdb_data, cdb_br_target, cdb_is_branch, cdb_br_taken, cdb_mispred, e_data[c-2], e_tgt[c-2], e_flag[c-2]);
            end
            exp_exec++;
         end
      end
   endtask

   task automatic test_flush();
      for (int c = 0; c < 8; c++) begin
         tick();
         flush = 1'b0;
         cdb_rdy = (c >= 3);
         if (c == 0)      set_issue(4'd0, 32'd1, 32'd1, TW'(30), 0, 0, 0, 0);
         else if (c == 1) set_issue(4'd0, 32'd2, 32'd2, TW'(31), 0, 0, 0, 0);
         else if (c == 2) begin set_issue(4'd0, 32'd3, 32'd3, TW'(32), 0, 0, 0, 0); flush = 1'b1; end
         else if (c == 4) set_issue(4'd0, 32'd40, 32'd2, TW'(33), 0, 0, 0, 0);
         else set_idle();
         @(negedge clk);
         if (c == 2) begin
            checks++;
            if (issue_rdy !== 1'b0 || cdb_vld !== 1'b1 || cdb_data !== 32'd2) begin
               errors++; $display("FAIL flush_cycle got rdy=%b vld=%b data=%h want 0/1/00000002", issue_rdy, cdb_vld, cdb_data);
            end
            exp_stall++;
         end else if (c >= 3 && c <= 5) begin
            checks++;
            if (cdb_vld !== 1'b0 || issue_rdy !== 1'b1) begin
               errors++; $display("FAIL flush_empty c=%0d got vld=%b rdy=%b want 0/1", c, cdb_vld, issue_rdy);
            end
         end else if (c == 6) begin
            checks++;
            if (cdb_vld !== 1'b1 || cdb_data !== 32'd42 || cdb_tag !== TW'(33)) begin
               errors++; $display("FAIL flush_after got vld=%b data=%h tag=%0d want 1/0000002a/33", cdb_vld, cdb_data, cdb_tag);
            end
            exp_exec++;
         end
      end
      checks++;
      if (exec_cnt !== perf_exp(exp_exec) || stall_cnt !== perf_exp(exp_stall)) begin
         errors++; $display("FAIL flush_counters got %0d/%0d want %0d/%0d", exec_cnt, stall_cnt, perf_exp(exp_exec), perf_exp(exp_stall));
      end
   endtask

   task automatic test_random();
      exp_t e;
      logic exp_rdy, exp_vld;
      logic [3:0] op;
      logic [31:0] a;
      q.delete();
      for (int cyc = 0; cyc < 306; cyc++) begin
         tick();
         if (cyc < 300) begin
            op = 4'($urandom_range(0, 13));
            a = $urandom;
            set_issue(op, a, ($urandom_range(0, 3) == 0) ? a : $urandom, TW'($urandom),
                      (op >= 4'd8) && ($urandom_range(0, 1) == 1), $urandom, $urandom, 1'($urandom));
            issue_vld = ($urandom_range(0, 3) != 0);
            flush = ($urandom_range(0, 19) == 0);
            cdb_rdy = ($urandom_range(0, 3) != 0);
         end else begin
            set_idle();
            cdb_rdy = 1'b1;
         end
         @(negedge clk);
         exp_rdy = !flush && (q.size() < 2 || cdb_rdy);
         exp_vld = (q.size() > 0) && (cyc >= q[0].acc + 2);
         checks++;
         if (issue_rdy !== exp_rdy || cdb_vld !== exp_vld) begin
            errors++; $display("FAIL rand_hs cyc=%0d got rdy=%b vld=%b want %b/%b", cyc, issue_rdy, cdb_vld, exp_rdy, exp_vld);
         end
         if (exp_vld && cdb_vld === 1'b1) begin
            e = q[0];
            checks++;
            if ({cdb_tag, cdb_data, cdb_is_branch, cdb_br_taken, cdb_br_target, cdb_mispred} !==
                {e.tag, e.data, e.is_br, e.taken, e.target, e.mispred}) begin
               errors++; $display("FAIL rand_res cyc=%0d got tag=%0d data=%h br=%b tk=%b tgt=%h mp=%b want tag=%0d data=%h br=%b tk=%b tgt=%h mp=%b",
                  cyc, cdb_tag, cdb_data, cdb_is_branch, cdb_br_taken, cdb_br_target, cdb_mispred, e.tag, e.data, e.is_br, e.taken, e.target, e.mispred);
            end
         end
         if (exp_vld && cdb_rdy) begin void'(q.pop_front()); exp_exec++; end
         if (exp_vld && !cdb_rdy) exp_stall++;
         if (flush) q.delete();
         if (issue_vld && exp_rdy) q.push_back(ref_model(alu_op, src1, src2, rob_tag, is_branch, pc, br_offset, pred_taken, cyc));
      end
      checks++;
      if (q.size() != 0) begin errors++; $display("FAIL rand_drain got %0d pending want 0", q.size()); end
      checks++;
      if (exec_cnt !== perf_exp(exp_exec) || stall_cnt !== perf_exp(exp_stall)) begin
         errors++; $display("FAIL rand_counters got %0d/%0d want %0d/%0d", exec_cnt, stall_cnt, perf_exp(exp_exec), perf_exp(exp_stall));
      end
   endtask

   task automatic test_async_reset();
      cdb_rdy = 1'b0;
      for (int c = 0; c < 3; c++) begin
         tick();
         if (c == 0)      set_issue(4'd0, 32'd1, 32'd2, TW'(40), 0, 0, 0, 0);
         else if (c == 1) set_issue(4'd0, 32'd3, 32'd4, TW'(41), 0, 0, 0, 0);
         else set_idle();
         @(negedge clk);
      end
      checks++;
      if (cdb_vld !== 1'b1) begin errors++; $display("FAIL arst_pre got vld=%b want 1", cdb_vld); end
      exp_stall++;
      #2 rst_n = 1'b0;
      #1;
      exp_exec = 0; exp_stall = 0;
      checks++;
      if (cdb_vld !== 1'b0 || cdb_data !== 32'd0 || cdb_tag !== '0 || exec_cnt !== 32'd0 || stall_cnt !== 32'd0) begin
         errors++; $display("FAIL arst_now got vld=%b data=%h tag=%0d cnt=%0d/%0d want all 0", cdb_vld, cdb_data, cdb_tag, exec_cnt, stall_cnt);
      end
      @(posedge clk);
      #3 rst_n = 1'b1;
      tick();
      cdb_rdy = 1'b1;
      set_issue(4'd0, 32'd9, 32'd9, TW'(7), 0, 0, 0, 0);
      @(negedge clk);
      checks++;
      if (issue_rdy !== 1'b1) begin errors++; $display("FAIL arst_rdy got %b want 1", issue_rdy); end
      tick(); set_idle();
      tick();
      @(negedge clk);
      checks++;
      if (cdb_vld !== 1'b1 || cdb_data !== 32'd18 || cdb_tag !== TW'(7)) begin
         errors++; $display("FAIL arst_result got vld=%b data=%h tag=%0d want 1/00000012/7", cdb_vld, cdb_data, cdb_tag);
      end
      exp_exec++;
      tick();
      @(negedge clk);
      checks++;
      if (cdb_vld !== 1'b0 || exec_cnt !== perf_exp(exp_exec) || stall_cnt !== perf_exp(exp_stall)) begin
         errors++; $display("FAIL arst_after got vld=%b cnt=%0d/%0d want 0/%0d/%0d", cdb_vld, exec_cnt, stall_cnt, perf_exp(exp_exec), perf_exp(exp_stall));
      end
   endtask

   initial begin
      test_reset();
      test_add_latency();
      test_back_to_back();
      test_backpressure();
      test_branch();
      test_flush();
      test_random();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "timeout");
   end
endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
Integer execute pipeline for one ALU lane of the out-of-order core. It accepts one issued micro-op per cycle from the ALU reservation station through a valid/ready handshake and computes the result with the existing combinational alu module. It resolves conditional branches and returns result, ROB tag and branch outcome on its common-data-bus (CDB) port, with full backpressure and pipeline flush.

Parameters:
ROB_TAG_W, `ROB_TAG_WIDTH, width of the ROB tag carried with each micro-op
DATA_W, `RV32_DATA_WIDTH, operand/result width (32)

Ports:
i_clk  in  1  core clock
i_rst_n  in  1  asynchronous active-low reset
i_flush  in  1  kill all in-flight micro-ops (mispredict/exception)
i_issue_vld  in  1  issue request valid
o_issue_rdy  out  1  unit can accept the micro-op this cycle
i_alu_op  in  `ALU_OP_SEL  ALU operation code
i_src1  in  DATA_W  operand 1
i_src2  in  DATA_W  operand 2 (register or immediate)
i_rob_tag  in  ROB_TAG_W  destination ROB tag
i_is_branch  in  1  micro-op is a conditional branch; i_alu_op is one of SEQ/SNE/SLT/SGE/SLTU/SGEU
i_pc  in  DATA_W  instruction PC
i_br_offset  in  DATA_W  sign-extended branch offset
i_pred_taken  in  1  frontend prediction
o_cdb_vld  out  1  result valid
i_cdb_rdy  in  1  CDB arbiter grants this lane
o_cdb_tag  out  ROB_TAG_W  result ROB tag
o_cdb_data  out  DATA_W  ALU result; PC+4 for branches
o_cdb_is_branch  out  1  result belongs to a branch
o_cdb_br_taken  out  1  resolved direction
o_cdb_br_target  out  DATA_W  taken target: PC+offset
o_cdb_mispred  out  1  br_taken != pred_taken, gated by is_branch
o_exec_cnt  out  32  completed micro-ops (optional feature)
o_stall_cnt  out  32  CDB backpressure cycles (optional feature)

Behaviour:
- Reset is async, active-low, on i_rst_n. It clears the EX and WB valid bits. All o_cdb_* outputs and both counters reset to 0. o_issue_rdy is 1 out of reset.
- Two registered stages:
  - EX latches the issue fields.
  - The alu instance and the PC+offset/PC+4 adders operate on the EX register.
  - WB registers the result and drives the o_cdb_* outputs directly from flops.
- Latency: a micro-op accepted in cycle N presents o_cdb_vld in cycle N+2 if there is no backpressure. Throughput is 1 per cycle.
- Handshakes:
  - Issue transfer = i_issue_vld && o_issue_rdy.
  - CDB transfer = o_cdb_vld && i_cdb_rdy.
  - wb_adv = !wb_vld || i_cdb_rdy.
  - ex_adv = !ex_vld || wb_adv.
  - o_issue_rdy = ex_adv && !i_flush. It is combinational on i_cdb_rdy, and there is no comb path from i_issue_vld.
- Stall: while o_cdb_vld && !i_cdb_rdy, the WB contents hold stable. EX holds if it is full. No micro-op is lost or duplicated.
- Branch: br_taken = alu_res[0]. data = PC+4, target = PC+offset, with 32-bit wrap-around. For non-branches, br_taken, target and mispred are 0.
- Flush:
  - i_flush at the clock edge clears EX and WB valid bits.
  - An issue presented in the same cycle is not accepted (rdy is 0).
  - A CDB transfer completing in the flush cycle still counts as delivered; the consumer must ignore it.
  - Flush has priority over all advances.
- Operand values with o_cdb_vld = 0 are don't-care, but the tag/data flops only load on advance, to limit toggling.

Optional Feature:
ALU_EXEC_PERF_EN.
- Defined:
  - o_exec_cnt increments on each CDB transfer.
  - o_stall_cnt increments each cycle with o_cdb_vld && !i_cdb_rdy.
  - Both are 32-bit, wrap 0xFFFFFFFF->0, are unaffected by i_flush, and reset to 0.
- Undefined: both ports remain and are tied to 0. No counter flops are generated.

Decomposition:
- Shared constants.vh holds:
  - `RV32_DATA_WIDTH, `ALU_OP_SEL, `ROB_TAG_WIDTH.
  - The `ALU_OP_* encodings. The branch compare ops are the existing SEQ/SNE/SLT/SGE/SLTU/SGEU codes; no new opcodes.
- Sub-module: one instance of the existing alu module. No new sub-module; the pipeline control stays inline.

Test Plan:
1. Reset then issue ADD 5+7, tag 3, i_cdb_rdy=1 -> o_cdb_vld exactly 2 cycles later with data 12 and tag 3. Outputs are 0 during and after reset.
2. Back-to-back: issue SUB 1-2, SRA 0x80000000>>4, SLTU 1<2 on consecutive cycles -> data 0xFFFFFFFF, 0xF8000000, 1 on consecutive cycles.
3. Backpressure: hold i_cdb_rdy=0 for 5 cycles while issuing 3 ops:
   - o_issue_rdy drops after 2 accepts.
   - WB stays stable.
   - On release, all 3 results arrive in order.
   - o_stall_cnt=5 with ALU_EXEC_PERF_EN.
4. Branch: SLT src1=-1, src2=0, pc=0x100, off=0x20, pred=0 -> taken=1, target=0x120, data=0x104, mispred=1. Repeat with SGEU -> taken=0, mispred=0.
5. Flush with both stages full and i_issue_vld=1 -> next cycle o_cdb_vld=0, issue not accepted. A new issue afterwards completes normally.
6. Assert i_rst_n low mid-stall for 1 cycle -> o_cdb_vld and counters are 0 immediately (async). The unit accepts again after release.
